// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a burst-framed valid/ready stream.
// Define FIFO_STREAM_READER_STATS_EN to add the word_count/burst_count outputs.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_read_request,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]      word_count,
    output logic [15:0]      burst_count
`endif
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [BW-1:0]    beat;
    logic             pop;
    logic [2:0]       occ_nxt;
    logic [1:0]       kept;

    assign out_valid         = occ != 2'd0;
    assign out_data          = head;
    assign out_last          = out_valid && beat == LAST_BEAT;
    assign pop               = out_valid && out_ready;
    assign occ_nxt           = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign kept              = occ - {1'b0, pop};
    assign fifo_read_request = !fifo_empty && occ_nxt < 3'd2;

    // two-entry buffer: pop shifts tail to head, arriving data lands in the first free slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ      <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            beat     <= '0;
        end else begin
            occ      <= occ_nxt[1:0];
            inflight <= fifo_read_request;
            head     <= (inflight && kept == 2'd0) ? fifo_data : (pop ? tail : head);
            tail     <= (inflight && kept == 2'd1) ? fifo_data : tail;
            if (pop)
                beat <= out_last ? '0 : beat + BW'(1);
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    // accepted beat and completed burst counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count  <= '0;
            burst_count <= '0;
        end else if (pop) begin
            word_count  <= word_count + 32'd1;
            burst_count <= burst_count + {15'd0, out_last};
        end
    end
`endif
endmodule
